fsgnj_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered floating-point sign-injection unit (FSGNJ / FSGNJN / FSGNJX) between NREQ requesters in the floating ALU. Each requester presents rs1, rs2 and an op code with a valid/ready handshake. The block grants one requester per cycle and computes the sign-injected result into a single output register. The result is returned with the winning requester's ID over a valid/ready response port with full backpressure.

---
 rtl/fsgnj_arbiter.sv | 137 +++++++++++++
 tb/tb_fsgnj_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsgnj_arbiter.sv
// Round-robin arbiter in front of one registered FP sign-injection unit.
// NREQ requesters compete each cycle. The winner's result is loaded into a
// single response register and returned with the winner's ID. The response
// port supports full backpressure, and a drain can overlap a new grant.
module fsgnj_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 FLUSH,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_rs1,
  input  logic [NREQ*32-1:0]   req_rs2,
  input  logic [NREQ*2-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err
);

  localparam logic [1:0] OpSgnj  = 2'b00;
  localparam logic [1:0] OpSgnjn = 2'b01;
  localparam logic [1:0] OpSgnjx = 2'b10;
  localparam logic [1:0] OpRsvd  = 2'b11;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           valid_q, valid_d;
  logic [31:0]    data_q, data_d;
  logic [IDW-1:0] id_q, id_d;
  logic           err_q, err_d;

  logic           any_win;
  logic [IDW-1:0] win_idx;
  logic [IDW:0]   cand;
  logic           slot_free;
  logic           grant;
  logic [31:0]    sel_rs1, sel_rs2;
  logic [1:0]     sel_op;
  logic [31:0]    res_data;
  logic           res_err;
  logic [IDW-1:0] ptr_after_win;

  assign slot_free = !valid_q || rsp_ready;
  // RST is folded in so no grant can leak out while the block is held in reset.
  assign grant     = any_win && slot_free && !FLUSH && RST;

  // Rotating priority search: first valid index at or after ptr, wrapping mod NREQ.
  always_comb begin
    any_win = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      // One conditional subtract is enough: ptr < NREQ and k < NREQ.
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!any_win && req_valid[cand[IDW-1:0]]) begin
        any_win = 1'b1;
        win_idx = cand[IDW-1:0];
      end
    end
  end

  // One-hot grant to the winner when the response slot can take a new result.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_idx] = 1'b1;
  end

  assign sel_rs1 = req_rs1[32*win_idx +: 32];
  assign sel_rs2 = req_rs2[32*win_idx +: 32];
  assign sel_op  = req_op[2*win_idx +: 2];

  // Sign injection on the winner's operands; the magnitude always comes from rs1.
  always_comb begin
    res_data = sel_rs1;
    res_err  = 1'b0;
    unique case (sel_op)
      OpSgnj:  res_data = {sel_rs2[31], sel_rs1[30:0]};
      OpSgnjn: res_data = {~sel_rs2[31], sel_rs1[30:0]};
      OpSgnjx: res_data = {sel_rs1[31] ^ sel_rs2[31], sel_rs1[30:0]};
      OpRsvd:  res_err  = 1'b1;
      default: res_err  = 1'b1;
    endcase
  end

  assign ptr_after_win = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;

  // Next state: FLUSH beats a grant, a grant beats a drain, otherwise hold.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    err_d   = err_q;
    if (FLUSH) begin
      ptr_d   = '0;
      valid_d = 1'b0;
      data_d  = '0;
      id_d    = '0;
      err_d   = 1'b0;
    end else if (grant) begin
      ptr_d   = ptr_after_win;
      valid_d = 1'b1;
      data_d  = res_data;
      id_d    = win_idx;
      err_d   = res_err;
    end else if (rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_fsgnj_arbiter.sv
// Bench for fsgnj_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run checked against a cycle-level reference model.
module tb_fsgnj_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b0;
  logic                 FLUSH = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_rs1 = '0;
  logic [NREQ*32-1:0]   req_rs2 = '0;
  logic [NREQ*2-1:0]    req_op = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [31:0]          rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_err;

  fsgnj_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLUSH     (FLUSH),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic        m_valid = 1'b0;
  logic [31:0] m_data = '0;
  int          m_id = 0;
  logic        m_err = 1'b0;
  int          m_ptr = 0;
  int          g_last = -1;

  typedef struct {
    int unsigned rq;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {err, data} from the instruction definitions.
  function automatic logic [32:0] ref_calc(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic s;
    if (op == 2'd3) return {1'b1, a};
    if (op == 2'd0) s = b[31];
    else if (op == 2'd1) s = !b[31];
    else s = a[31] != b[31];
    return {1'b0, s, a[30:0]};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_id = 0; m_err = 1'b0; m_ptr = 0; g_last = -1;
  endtask

  task automatic check_rsp(input string tag);
    check({tag, "_valid"}, 64'(rsp_valid), 64'(m_valid));
    check({tag, "_data"}, 64'(rsp_data), 64'(m_data));
    check({tag, "_id"}, 64'(rsp_id), 64'(m_id));
    check({tag, "_err"}, 64'(rsp_err), 64'(m_err));
  endtask

  // One clock: check grant mid-cycle, advance model across the edge, check response.
  task automatic step();
    int w;
    int idx;
    logic [NREQ-1:0] exp_rdy;
    logic [32:0] r;
    @(negedge CLK);
    w = -1;
    if (RST && !FLUSH && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge CLK);
    #1;
    if (FLUSH) begin
      m_valid = 1'b0; m_data = '0; m_id = 0; m_err = 1'b0; m_ptr = 0;
    end else if (w >= 0) begin
      r = ref_calc(req_op[2*w +: 2], req_rs1[32*w +: 32], req_rs2[32*w +: 32]);
      m_err = r[32]; m_data = r[31:0]; m_id = w; m_valid = 1'b1; m_ptr = (w + 1) % NREQ;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    g_last = w;
    check_rsp("rsp");
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[2*i +: 2]   = op;
    req_rs1[32*i +: 32] = a;
    req_rs2[32*i +: 32] = b;
  endtask

  initial begin
    logic [31:0] held_data;
    logic [IDW-1:0] held_id;

    vecs[0] = '{0, 2'b00, 32'h40866666, 32'hBF000000, 32'hC0866666, 1'b0};
    vecs[1] = '{2, 2'b00, 32'hC0CCCCCC, 32'hBF000000, 32'hC0CCCCCC, 1'b0};
    vecs[2] = '{2, 2'b01, 32'hC0CCCCCC, 32'hBF000000, 32'h40CCCCCC, 1'b0};
    vecs[3] = '{2, 2'b10, 32'hC0CCCCCC, 32'hBF000000, 32'h40CCCCCC, 1'b0};
    vecs[4] = '{2, 2'b11, 32'hC0CCCCCC, 32'hBF000000, 32'hC0CCCCCC, 1'b1};

    // Reset state, with requests pending while RST is low
    req_valid = '1;
    rsp_ready = 1'b1;
    #2;
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check_rsp("reset");
    req_valid = '0;
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      req_valid = '0;
      set_req(int'(vecs[v].rq), vecs[v].op, vecs[v].rs1, vecs[v].rs2);
      req_valid[vecs[v].rq] = 1'b1;
      rsp_ready = 1'b1;
      step();
      check("vec_valid", 64'(rsp_valid), 64'(1));
      check("vec_data", 64'(rsp_data), 64'(vecs[v].exp_data));
      check("vec_err", 64'(rsp_err), 64'(vecs[v].exp_err));
      check("vec_id", 64'(rsp_id), 64'(vecs[v].rq));
      req_valid = '0;
    end

    // Round-robin order from ptr=0 with all requesters valid
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 2'(i % 3), 32'h3F800000 + i, 32'h80000000);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_order", 64'(rsp_id), 64'(k % 4));
      check("rr_valid", 64'(rsp_valid), 64'(1));
    end

    // Backpressure: result held, no grants while rsp_ready is low
    req_valid = 4'b0001;
    step();
    held_data = rsp_data;
    held_id = rsp_id;
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_ready", 64'(req_ready), 64'(0));
      check("bp_data", 64'(rsp_data), 64'(held_data));
      check("bp_id", 64'(rsp_id), 64'(held_id));
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'(4'b0010));
    step();
    check("bp_next_id", 64'(rsp_id), 64'(1));

    // Drain and grant in the same cycle
    req_valid = 4'b1000;
    step();
    check("dg_valid", 64'(rsp_valid), 64'(1));
    check("dg_id", 64'(rsp_id), 64'(3));

    // FLUSH while FULL
    req_valid = '1;
    FLUSH = 1'b1;
    #1;
    check("flush_no_grant", 64'(req_ready), 64'(0));
    step();
    check("flush_valid", 64'(rsp_valid), 64'(0));
    FLUSH = 1'b0;

    // Asynchronous reset mid-operation
    req_valid = 4'b0001;
    step();
    check("pre_rst_valid", 64'(rsp_valid), 64'(1));
    RST = 1'b0;
    #2;
    model_reset();
    check("arst_ready", 64'(req_ready), 64'(0));
    check_rsp("arst");
    req_valid = '0;
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;
    req_valid = 4'b0101;
    step();
    check("post_rst_id", 64'(rsp_id), 64'(0));

    // Randomized run; operands held while valid and not granted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!(req_valid[i] && g_last != i && $urandom_range(0, 9) != 0)) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          set_req(i, 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      FLUSH = ($urandom_range(0, 49) == 0);
      step();
    end
    FLUSH = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
